// File: rtl/core_pkg.sv
// Encodings shared by the decoder, forwarding unit and writeback stage of the RV32 core.
package core_pkg;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;
    localparam logic [1:0] WB_SEL_IMM  = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Selects and extends the byte/halfword/word addressed by a load from a word-aligned read.
module load_align
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      ofs,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data,
    output logic            err
);

    logic signed [7:0]  byte_sel;
    logic signed [15:0] half_sel;

    always_comb begin
        case (ofs)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = ofs[1] ? rdata[31:16] : rdata[15:0];
    end

    // Errored loads return zero so the stage never forwards stale memory data.
    always_comb begin
        data = '0;
        err  = 1'b0;
        case (funct3)
            F3_LB:   data = XLEN'(byte_sel);
            F3_LBU:  data = XLEN'($unsigned(byte_sel));
            F3_LH:   begin
                err  = ofs[0];
                data = ofs[0] ? '0 : XLEN'(half_sel);
            end
            F3_LHU:  begin
                err  = ofs[0];
                data = ofs[0] ? '0 : XLEN'($unsigned(half_sel));
            end
            F3_LW:   begin
                err  = (ofs != 2'd0);
                data = (ofs != 2'd0) ? '0 : rdata;
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_unit.sv
// MEM/WB pipeline register: formats writeback data, drives the register-file write port
// and the WB forwarding source, and counts retired instructions.
module wb_unit
    import core_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_valid,
    input  logic             wb_stall,
    input  logic             wb_flush,
    input  logic             mem_reg_write,
    input  logic [4:0]       mem_rd,
    input  logic [1:0]       mem_wb_sel,
    input  logic [2:0]       mem_funct3,
    input  logic [XLEN-1:0]  mem_alu_result,
    input  logic [XLEN-1:0]  mem_rdata,
    input  logic [XLEN-1:0]  mem_pc_plus4,
    input  logic [XLEN-1:0]  mem_imm,
    output logic             rf_wr_en,
    output logic [4:0]       rf_rd,
    output logic [XLEN-1:0]  rf_wr_data,
    output logic             wb_valid,
    output logic             load_err,
    output logic [CNT_W-1:0] instret
);

    logic [XLEN-1:0] ld_data_p0;
    logic            ld_err_p0;
    logic            err_p0;
    logic [XLEN-1:0] fmt_data_p0;

    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata  (mem_rdata),
        .ofs    (mem_alu_result[1:0]),
        .funct3 (mem_funct3),
        .data   (ld_data_p0),
        .err    (ld_err_p0)
    );

    assign err_p0 = (mem_wb_sel == WB_SEL_LOAD) & ld_err_p0;

    always_comb begin
        case (mem_wb_sel)
            WB_SEL_LOAD: fmt_data_p0 = ld_data_p0;
            WB_SEL_PC4:  fmt_data_p0 = mem_pc_plus4;
            WB_SEL_IMM:  fmt_data_p0 = mem_imm;
            default:     fmt_data_p0 = mem_alu_result;
        endcase
    end

    // ---- MEM -> WB boundary ----
    always_ff @(posedge clk) begin
        if (!rst) begin
            rf_wr_en   <= 1'b0;
            rf_rd      <= '0;
            rf_wr_data <= '0;
            wb_valid   <= 1'b0;
            load_err   <= 1'b0;
            instret    <= '0;
        end else if (wb_flush) begin
            rf_wr_en <= 1'b0;
            wb_valid <= 1'b0;
            load_err <= 1'b0;
        end else if (!wb_stall) begin
            wb_valid   <= mem_valid;
            rf_rd      <= mem_rd;
            rf_wr_data <= fmt_data_p0;
            rf_wr_en   <= mem_valid & mem_reg_write & (mem_rd != 5'd0) & ~err_p0;
            load_err   <= mem_valid & err_p0;
            if (mem_valid)
                instret <= instret + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_wb_unit.sv
// Directed and randomized checks of wb_unit against a behavioural writeback model.
module tb_wb_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, wb_stall, wb_flush, mem_reg_write;
    logic [4:0]  mem_rd;
    logic [1:0]  mem_wb_sel;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_alu_result, mem_rdata, mem_pc_plus4, mem_imm;

    logic        rf_wr_en, wb_valid, load_err;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wr_data;
    logic [63:0] instret;

    logic        w_rf_wr_en, w_wb_valid, w_load_err;
    logic [4:0]  w_rf_rd;
    logic [31:0] w_rf_wr_data;
    logic [3:0]  w_instret;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state
    bit          m_en, m_valid, m_err, m_known;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    longint unsigned m_cnt;
    int          m_cnt4;

    always #5 clk = ~clk;

    wb_unit dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .wb_stall(wb_stall), .wb_flush(wb_flush),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_wb_sel(mem_wb_sel),
        .mem_funct3(mem_funct3), .mem_alu_result(mem_alu_result), .mem_rdata(mem_rdata),
        .mem_pc_plus4(mem_pc_plus4), .mem_imm(mem_imm),
        .rf_wr_en(rf_wr_en), .rf_rd(rf_rd), .rf_wr_data(rf_wr_data), .wb_valid(wb_valid),
        .load_err(load_err), .instret(instret)
    );

    wb_unit #(.CNT_W(4)) u_wrap (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .wb_stall(wb_stall), .wb_flush(wb_flush),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_wb_sel(mem_wb_sel),
        .mem_funct3(mem_funct3), .mem_alu_result(mem_alu_result), .mem_rdata(mem_rdata),
        .mem_pc_plus4(mem_pc_plus4), .mem_imm(mem_imm),
        .rf_wr_en(w_rf_wr_en), .rf_rd(w_rf_rd), .rf_wr_data(w_rf_wr_data), .wb_valid(w_wb_valid),
        .load_err(w_load_err), .instret(w_instret)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Writeback value from the ISA rules: shift the word, mask, sign-extend by arithmetic.
    task automatic model_fmt(output logic [31:0] d, output bit e);
        longint v;
        int unsigned ofs;
        ofs = mem_alu_result % 4;
        e = 1'b0;
        d = 32'd0;
        case (mem_wb_sel)
            2'd0: d = mem_alu_result;
            2'd2: d = mem_pc_plus4;
            2'd3: d = mem_imm;
            default: begin
                case (mem_funct3)
                    3'd0, 3'd4: begin
                        v = (longint'(mem_rdata) >> (8 * ofs)) & 255;
                        if (mem_funct3 == 3'd0 && v > 127) v = v - 256;
                        d = 32'(v);
                    end
                    3'd1, 3'd5: begin
                        if (ofs % 2 != 0) e = 1'b1;
                        else begin
                            v = (longint'(mem_rdata) >> (16 * (ofs / 2))) & 65535;
                            if (mem_funct3 == 3'd1 && v > 32767) v = v - 65536;
                            d = 32'(v);
                        end
                    end
                    3'd2: begin
                        if (ofs != 0) e = 1'b1;
                        else d = mem_rdata;
                    end
                    default: e = 1'b1;
                endcase
            end
        endcase
    endtask

    task automatic model_update();
        logic [31:0] d;
        bit e;
        if (!rst) begin
            m_en = 0; m_valid = 0; m_err = 0; m_rd = '0; m_data = '0; m_known = 1;
            m_cnt = 0; m_cnt4 = 0;
        end else if (wb_flush) begin
            m_en = 0; m_valid = 0; m_err = 0; m_known = 0;
        end else if (!wb_stall) begin
            m_valid = mem_valid;
            if (mem_valid) begin
                model_fmt(d, e);
                m_err   = e;
                m_en    = mem_reg_write && (mem_rd != 0) && !e;
                m_rd    = mem_rd;
                m_data  = d;
                m_known = 1;
                m_cnt   = m_cnt + 1;
                m_cnt4  = (m_cnt4 + 1) % 16;
            end else begin
                m_en = 0; m_err = 0; m_known = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".wr_en"}, 64'(rf_wr_en), 64'(m_en));
        chk({tag, ".valid"}, 64'(wb_valid), 64'(m_valid));
        chk({tag, ".load_err"}, 64'(load_err), 64'(m_err));
        chk({tag, ".instret"}, instret, m_cnt);
        chk({tag, ".instret4"}, 64'(w_instret), 64'(m_cnt4));
        if (m_known) begin
            chk({tag, ".rd"}, 64'(rf_rd), 64'(m_rd));
            chk({tag, ".data"}, 64'(rf_wr_data), 64'(m_data));
        end
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_update();
        #1;
        check_all(tag);
    endtask

    task automatic rand_fields();
        mem_reg_write  = 1'($urandom);
        mem_rd         = 5'($urandom);
        mem_wb_sel     = 2'($urandom);
        mem_funct3     = 3'($urandom);
        mem_alu_result = $urandom;
        mem_rdata      = $urandom;
        mem_pc_plus4   = $urandom;
        mem_imm        = $urandom;
    endtask

    logic [2:0]  ld_f3  [6] = '{3'd0, 3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
    logic [1:0]  ld_ofs [6] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd0};
    logic [31:0] ld_exp [6] = '{32'h0000007F, 32'hFFFFFFFF, 32'h00000080,
                                32'hFFFF80FF, 32'h00007F01, 32'h80FF7F01};
    logic [2:0]  er_f3  [3] = '{3'd2, 3'd1, 3'd3};
    logic [1:0]  er_ofs [3] = '{2'd2, 2'd1, 2'd0};

    initial begin
        longint unsigned cnt_before;
        rst = 1'b0; mem_valid = 1'b1; wb_stall = 1'b0; wb_flush = 1'b0;
        rand_fields();
        cyc("rst0");
        cyc("rst1");
        chk("rst.instret", instret, 64'd0);
        chk("rst.wr_en", 64'(rf_wr_en), 64'd0);

        rst = 1'b1; mem_reg_write = 1'b1; mem_wb_sel = 2'd0; mem_rd = 5'd5;
        mem_alu_result = 32'h1234;
        cyc("first");
        chk("first.wr_en", 64'(rf_wr_en), 64'd1);
        chk("first.rd", 64'(rf_rd), 64'd5);
        chk("first.data", 64'(rf_wr_data), 64'h1234);
        chk("first.instret", instret, 64'd1);

        mem_rdata = 32'h80FF7F01; mem_wb_sel = 2'd1; mem_rd = 5'd7;
        for (int i = 0; i < 6; i++) begin
            mem_funct3 = ld_f3[i];
            mem_alu_result = ($urandom & ~32'h3) | 32'(ld_ofs[i]);
            cyc("load");
            chk($sformatf("load%0d.data", i), 64'(rf_wr_data), 64'(ld_exp[i]));
        end

        for (int i = 0; i < 3; i++) begin
            mem_funct3 = er_f3[i];
            mem_alu_result = ($urandom & ~32'h3) | 32'(er_ofs[i]);
            cnt_before = m_cnt;
            cyc("lderr");
            chk($sformatf("err%0d.load_err", i), 64'(load_err), 64'd1);
            chk($sformatf("err%0d.wr_en", i), 64'(rf_wr_en), 64'd0);
            chk($sformatf("err%0d.data", i), 64'(rf_wr_data), 64'd0);
            chk($sformatf("err%0d.instret", i), instret, cnt_before + 1);
        end

        mem_wb_sel = 2'd0; mem_rd = 5'd0;
        cyc("x0");
        chk("x0.wr_en", 64'(rf_wr_en), 64'd0);
        mem_rd = 5'd9; mem_wb_sel = 2'd2; mem_pc_plus4 = 32'h104;
        cyc("pc4");
        chk("pc4.data", 64'(rf_wr_data), 64'h104);
        mem_wb_sel = 2'd3; mem_imm = 32'hABCDE000;
        cyc("imm");
        chk("imm.data", 64'(rf_wr_data), 64'hABCDE000);

        cnt_before = m_cnt;
        wb_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_fields();
            mem_valid = 1'b1;
            cyc("stall");
            chk("stall.data", 64'(rf_wr_data), 64'hABCDE000);
            chk("stall.instret", instret, cnt_before);
        end
        wb_flush = 1'b1;
        cyc("flush");
        chk("flush.valid", 64'(wb_valid), 64'd0);
        chk("flush.wr_en", 64'(rf_wr_en), 64'd0);
        wb_flush = 1'b0; wb_stall = 1'b0;
        mem_reg_write = 1'b1; mem_rd = 5'd3; mem_wb_sel = 2'd0;
        cyc("recap");
        wb_stall = 1'b1; rst = 1'b0;
        cyc("rststall");
        chk("rststall.valid", 64'(wb_valid), 64'd0);
        chk("rststall.data", 64'(rf_wr_data), 64'd0);
        chk("rststall.instret", instret, 64'd0);
        rst = 1'b1; wb_stall = 1'b0;

        for (int i = 0; i < 300; i++) begin
            rand_fields();
            mem_valid = ($urandom_range(0, 3) != 0);
            wb_stall  = ($urandom_range(0, 5) == 0);
            wb_flush  = ($urandom_range(0, 7) == 0);
            rst       = ($urandom_range(0, 49) != 0);
            cyc("rand");
        end

        rst = 1'b0; wb_stall = 1'b0; wb_flush = 1'b0;
        cyc("wraprst");
        rst = 1'b1; mem_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            rand_fields();
            cyc("wrap");
        end
        chk("wrap.instret4", 64'(w_instret), 64'd1);
        chk("wrap.instret64", instret, 64'd17);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_unit.md
Name: wb_unit

Overview:
- MEM/WB pipeline register and writeback-data formatter for the pipelined RV32 core.
- Captures the MEM-stage result and aligns and extends load data.
- Drives the register file's write port: write enable, destination register, write data.
- Exports the same registered values as the WB-stage forwarding source, and keeps a retired-instruction counter.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset: state clears on a rising clk edge while rst=0.
- mem_valid  input  1  MEM stage presents a valid instruction.
- wb_stall  input  1  hold all WB state.
- wb_flush  input  1  invalidate the WB slot.
- mem_reg_write  input  1  instruction writes rd.
- mem_rd  input  5  destination register.
- mem_wb_sel  input  2  source select: 00 ALU, 01 load, 10 PC+4, 11 immediate (LUI).
- mem_funct3  input  3  load type.
- mem_alu_result  input  XLEN  ALU result; for loads, the effective address.
- mem_rdata  input  XLEN  raw word read from data memory (word-aligned).
- mem_pc_plus4  input  XLEN  link value.
- mem_imm  input  XLEN  U-type immediate.
- rf_wr_en  output  1  register-file write enable.
- rf_rd  output  5  register-file destination.
- rf_wr_data  output  XLEN  register-file write data.
- wb_valid  output  1  WB slot holds a valid instruction (forwarding qualifier).
- load_err  output  1  the captured load was misaligned or had an illegal funct3.
- instret  output  CNT_W  count of retired instructions.

Behaviour:
- All outputs are flop outputs, with no combinational path from inputs. Latency from MEM inputs to rf_* is 1 cycle.
- The register file samples its write port mid-cycle, so rf_* must be stable for the whole cycle.
- Reset (rst=0 at a rising edge) clears rf_wr_en, rf_rd, rf_wr_data, wb_valid, load_err and instret to 0. Reset has priority over flush and stall, including mid-operation.
- Priority when rst=1: wb_flush, then wb_stall, then capture.
- Flush: wb_valid=0, rf_wr_en=0, load_err=0. Data and rd fields are don't-care; instret is unchanged.
- Stall: every register holds. rf_wr_en keeps its value, so a repeated write of identical data is legal and idempotent. instret does not increment.
- Capture (no flush, no stall):
  - wb_valid <= mem_valid.
  - rf_rd <= mem_rd.
  - rf_wr_data <= formatted data (see below).
  - rf_wr_en <= mem_valid & mem_reg_write & (mem_rd != 0) & ~err.
  - load_err <= mem_valid & (mem_wb_sel == 01) & err.
- instret increments by 1 on each capture with mem_valid=1, including writes to x0 and errored loads. It wraps modulo 2^CNT_W.
- Format for wb_sel 00, 10, 11: pass through mem_alu_result, mem_pc_plus4 or mem_imm respectively.
- Load format: ofs = mem_alu_result[1:0].
  - funct3 000 LB: byte mem_rdata[8*ofs +: 8], sign-extended.
  - funct3 100 LBU: same byte, zero-extended.
  - funct3 001 LH: halfword mem_rdata[16*ofs[1] +: 16], sign-extended. Error if ofs[0]=1.
  - funct3 101 LHU: same halfword, zero-extended. Same error rule.
  - funct3 010 LW: whole word. Error if ofs != 00.
  - funct3 011, 110, 111: illegal, error.
- On error, rf_wr_data <= 0 and the write is suppressed.
- When mem_valid=0 on a capture: wb_valid=0 and rf_wr_en=0; data fields are don't-care.

Decomposition:
- Shared package (core_pkg) holds the WB_SEL_ALU/LOAD/PC4/IMM encodings and the F3_LB/LH/LW/LBU/LHU constants, reused by the decoder and the forwarding unit.
- One combinational sub-module, load_align: inputs (rdata, ofs, funct3), outputs (data, err). It is unit-testable on its own.
- The pipeline register and counter stay in wb_unit.

Test Plan:
- Reset: rst=0 for 2 cycles with mem_valid=1 -> all outputs 0. After rst=1 with mem_valid=1, wb_sel=00, rd=5, alu=0x1234, one edge -> rf_wr_en=1, rf_rd=5, rf_wr_data=0x00001234, instret=1.
- Load extension: rdata=0x80FF7F01.
  - LB ofs=1 -> 0x0000007F. LB ofs=2 -> 0xFFFFFFFF. LBU ofs=3 -> 0x00000080.
  - LH ofs=2 -> 0xFFFF80FF. LHU ofs=0 -> 0x00007F01. LW ofs=0 -> 0x80FF7F01.
- Errors: LW ofs=2, LH ofs=1, funct3=011 -> load_err=1, rf_wr_en=0, rf_wr_data=0, instret still increments.
- x0 and sources: rd=0, reg_write=1 -> rf_wr_en=0. wb_sel=10 with pc4=0x104 -> data 0x104. wb_sel=11 with imm=0xABCDE000 -> data 0xABCDE000.
- Stall/flush: capture, then stall for 3 cycles with new inputs -> outputs and instret unchanged. Flush with stall=1 -> wb_valid=0, rf_wr_en=0. rst=0 during a stall -> all outputs 0.
- Counter wrap: CNT_W=4, 17 valid captures -> instret=1.
